hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with MDU occupancy tracker
// Optional HAZARD_PERF_EN adds stall_cycles/flush_count performance counters.
module hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IFID_rs,
  input  logic [4:0] IFID_rt,
  input  logic       IFID_useRs,
  input  logic       IFID_useRt,
  input  logic       ID_jump,
  input  logic       ID_mdu_op,
  input  logic [4:0] IDEXE_rd,
  input  logic       IDEXE_load,
  input  logic       EXE_branch_taken,
  input  logic       EXE_mdu_start,
  input  logic       MEM_dm_wait,
  output logic       PC_stall,
  output logic       IFID_stall,
  output logic       IFID_flush,
  output logic       IDEXE_stall,
  output logic       IDEXE_flush,
  output logic       mdu_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lu;
  logic             mh;

  always_comb begin
    lu = IDEXE_load && (IDEXE_rd != 5'd0) &&
         ((IFID_useRs && (IFID_rs == IDEXE_rd)) ||
          (IFID_useRt && (IFID_rt == IDEXE_rd)));
    mh = mdu_busy && ID_mdu_op;
  end

  // Priority chain: dm_wait freezes, a taken branch discards ID, hazards bubble, then jumps.
  always_comb begin
    PC_stall    = 1'b0;
    IFID_stall  = 1'b0;
    IFID_flush  = 1'b0;
    IDEXE_stall = 1'b0;
    IDEXE_flush = 1'b0;
    if (!rst) begin
      if (MEM_dm_wait) begin
        PC_stall    = 1'b1;
        IFID_stall  = 1'b1;
        IDEXE_stall = 1'b1;
      end else if (EXE_branch_taken) begin
        IFID_flush  = 1'b1;
        IDEXE_flush = 1'b1;
      end else if (lu || mh) begin
        PC_stall    = 1'b1;
        IFID_stall  = 1'b1;
        IDEXE_flush = 1'b1;
      end else if (ID_jump) begin
        IFID_flush  = 1'b1;
      end
    end
  end

  // The MDU keeps counting through dm_wait; only the start handshake is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mdu_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EXE_mdu_start && !MEM_dm_wait) begin
            state    <= BUSY;
            cnt      <= CNT_W'(MDU_LAT - 1);
            mdu_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state    <= IDLE;
            mdu_busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (PC_stall) stall_cycles <= stall_cycles + 32'd1;
      if (IFID_flush || IDEXE_flush) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
